// File: rtl/dilithium_sign_seq.sv
// rtl/dilithium_sign_seq.sv - Dilithium signing-core operation sequencer
//
// Runs one sign operation on an external Dilithium core: pulses core reset
// and start, streams the key/message words from a source RAM into the core,
// then writes the signature words returned by the core into a result RAM.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   cmd_start, cmd_msg_len       operation request and message length (bytes)
//   busy, done, err              status: in progress / completion pulse / timeout
//   cycles, rejects              duration and core reject count of last operation
//   src_rd_en, src_addr          source RAM read (data returns one cycle later)
//   src_rdata
//   dst_wr_en, dst_addr          result RAM write
//   dst_wdata
//   core_rst, core_start         core control
//   core_mode
//   tx_valid, tx_ready, tx_data  word stream into the core
//   rx_valid, rx_ready, rx_data  word stream out of the core
//   core_rejects                 core reject counter
`timescale 1ns/1ps
module dilithium_sign_seq #(
  parameter int W          = 64,
  parameter int SEED_WORDS = 4,
  parameter int S1_WORDS   = 70,
  parameter int S2_WORDS   = 70,
  parameter int T0_WORDS   = 208,
  parameter int Z_WORDS    = 400,
  parameter int H_WORDS    = 11,
  parameter int AW         = 12,
  parameter int TIMEOUT    = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_start,
  input  logic [31:0]   cmd_msg_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   cycles,
  output logic [7:0]    rejects,
  output logic          src_rd_en,
  output logic [AW-1:0] src_addr,
  input  logic [W-1:0]  src_rdata,
  output logic          dst_wr_en,
  output logic [AW-1:0] dst_addr,
  output logic [W-1:0]  dst_wdata,
  output logic          core_rst,
  output logic          core_start,
  output logic [1:0]    core_mode,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [W-1:0]  tx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [W-1:0]  rx_data,
  input  logic [7:0]    core_rejects
);

  localparam logic [1:0] SIGN_MODE = 2'b01;
  localparam int UNLOAD_WORDS = Z_WORDS + H_WORDS + SEED_WORDS;
  localparam int MSG_BASE     = 3 * SEED_WORDS + S1_WORDS + S2_WORDS + T0_WORDS;
  localparam int RXW          = $clog2(UNLOAD_WORDS + 1);
  localparam int WDW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, CRST, START, LOAD, UNLOAD, FIN} state_t;

  // Load fields in transfer order; F_END marks that every read has been issued.
  typedef enum logic [3:0] {
    F_RHO, F_MLEN, F_TR, F_MSG, F_K, F_S1, F_S2, F_T0, F_END
  } field_t;

  state_t         state, state_next;
  field_t         fld;
  logic [1:0]     crst_cnt;
  logic [31:0]    msg_len;
  logic [31:0]    msg_words;
  logic [31:0]    widx;
  logic [31:0]    fld_len;
  logic [31:0]    fld_base;
  logic           inflight;
  logic           inflight_mlen;
  logic [W-1:0]   fifo_mem [2];
  logic           fifo_rd;
  logic           fifo_wr;
  logic [1:0]     fifo_cnt;
  logic [1:0]     occ;
  logic [RXW-1:0] rx_idx;
  logic [WDW-1:0] wd_cnt;
  logic [31:0]    cyc_cnt;
  logic [31:0]    cyc_inc;
  logic           in_xfer;
  logic           accept;
  logic           issue;
  logic           tx_fire;
  logic           rx_fire;
  logic           rx_last;
  logic           load_done;
  logic           wd_expire;

  // Message words = max(1, ceil(8*len/W)); computed once per command.
  function automatic logic [31:0] msg_word_count(input logic [31:0] len);
    logic [34:0] bits;
    logic [34:0] words;
    bits  = {len, 3'b000};
    words = (bits + 35'(W - 1)) / 35'(W);
    if (words == 35'd0) words = 35'd1;
    return 32'(words);
  endfunction

  always_comb begin
    fld_len  = 32'd1;
    fld_base = 32'd0;
    case (fld)
      F_RHO:  begin fld_len = 32'(SEED_WORDS); fld_base = 32'd0; end
      F_MLEN: begin fld_len = 32'd1;           fld_base = 32'd0; end
      F_TR:   begin fld_len = 32'(SEED_WORDS); fld_base = 32'(SEED_WORDS); end
      F_MSG:  begin fld_len = msg_words;       fld_base = 32'(MSG_BASE); end
      F_K:    begin fld_len = 32'(SEED_WORDS); fld_base = 32'(2 * SEED_WORDS); end
      F_S1:   begin fld_len = 32'(S1_WORDS);   fld_base = 32'(3 * SEED_WORDS); end
      F_S2:   begin fld_len = 32'(S2_WORDS);   fld_base = 32'(3 * SEED_WORDS + S1_WORDS); end
      F_T0:   begin fld_len = 32'(T0_WORDS);   fld_base = 32'(3 * SEED_WORDS + S1_WORDS + S2_WORDS); end
      default: ;
    endcase
  end

  assign in_xfer   = (state == LOAD) || (state == UNLOAD);
  assign accept    = (state == IDLE) && cmd_start;
  assign tx_valid  = (state == LOAD) && (fifo_cnt != 2'd0);
  assign tx_data   = tx_valid ? fifo_mem[fifo_rd] : '0;
  assign tx_fire   = tx_valid && tx_ready;
  assign rx_ready  = (state == UNLOAD);
  assign rx_fire   = rx_valid && rx_ready;
  assign rx_last   = rx_fire && (rx_idx == RXW'(UNLOAD_WORDS - 1));
  assign wd_expire = in_xfer && !tx_fire && !rx_fire && (wd_cnt == WDW'(TIMEOUT - 1));

  // Occupancy counts the read still in flight. A word leaving this cycle
  // frees its slot immediately, which keeps one word per cycle flowing.
  assign occ       = fifo_cnt + {1'b0, inflight};
  assign issue     = (state == LOAD) && (fld != F_END) && !wd_expire &&
                     ((occ < 2'd2) || tx_fire);
  assign load_done = (fld == F_END) && (fifo_cnt == 2'd0) && !inflight;

  // The length word is produced locally but still occupies an issue slot so
  // that it lands in the FIFO in order with the RAM words around it.
  assign src_rd_en = issue && (fld != F_MLEN);
  assign src_addr  = src_rd_en ? AW'(fld_base + widx) : '0;

  assign dst_wr_en = rx_fire;
  assign dst_addr  = rx_fire ? AW'(rx_idx) : '0;
  assign dst_wdata = rx_fire ? rx_data : '0;

  assign busy       = (state != IDLE);
  assign done       = (state == FIN);
  assign core_rst   = (state == CRST);
  assign core_start = (state == START);
  assign core_mode  = SIGN_MODE;

  assign cyc_inc = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (cmd_start) state_next = CRST;
      CRST:   if (crst_cnt == 2'd3) state_next = START;
      START:  state_next = LOAD;
      LOAD: begin
        if (wd_expire)      state_next = IDLE;
        else if (load_done) state_next = UNLOAD;
      end
      UNLOAD: begin
        if (wd_expire)    state_next = IDLE;
        else if (rx_last) state_next = FIN;
      end
      FIN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fld           <= F_RHO;
      crst_cnt      <= 2'd0;
      msg_len       <= 32'd0;
      msg_words     <= 32'd1;
      widx          <= 32'd0;
      inflight      <= 1'b0;
      inflight_mlen <= 1'b0;
      fifo_mem[0]   <= '0;
      fifo_mem[1]   <= '0;
      fifo_rd       <= 1'b0;
      fifo_wr       <= 1'b0;
      fifo_cnt      <= 2'd0;
      rx_idx        <= '0;
      wd_cnt        <= '0;
      cyc_cnt       <= 32'd0;
      cycles        <= 32'd0;
      rejects       <= 8'd0;
      err           <= 1'b0;
    end else begin
      crst_cnt <= (state == CRST) ? crst_cnt + 2'd1 : 2'd0;

      if (accept) begin
        msg_len   <= cmd_msg_len;
        msg_words <= msg_word_count(cmd_msg_len);
        fld       <= F_RHO;
        widx      <= 32'd0;
        rx_idx    <= '0;
        err       <= 1'b0;
      end

      if (wd_expire) begin
        err      <= 1'b1;
        inflight <= 1'b0;
        fifo_rd  <= 1'b0;
        fifo_wr  <= 1'b0;
        fifo_cnt <= 2'd0;
      end else begin
        inflight      <= issue;
        inflight_mlen <= issue && (fld == F_MLEN);
        if (issue) begin
          if (widx == fld_len - 32'd1) begin
            fld  <= field_t'(fld + 4'd1);
            widx <= 32'd0;
          end else begin
            widx <= widx + 32'd1;
          end
        end
        if (inflight) begin
          fifo_mem[fifo_wr] <= inflight_mlen ? W'(msg_len) : src_rdata;
          fifo_wr           <= ~fifo_wr;
        end
        if (tx_fire) fifo_rd <= ~fifo_rd;
        fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, tx_fire};
      end

      if (rx_fire) rx_idx <= rx_idx + RXW'(1);

      if ((state == START) || tx_fire || rx_fire || wd_expire) wd_cnt <= '0;
      else if (in_xfer)                                        wd_cnt <= wd_cnt + WDW'(1);

      // The start cycle counts as the first cycle of the operation.
      if (state == START)  cyc_cnt <= 32'd1;
      else if (in_xfer)    cyc_cnt <= cyc_inc;

      if (rx_last) begin
        cycles  <= cyc_inc;
        rejects <= core_rejects;
      end
    end
  end

endmodule
